// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver: S1 decodes the condition, S2 evaluates it and forms the target.
// Optional performance counters are enabled with `define BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN = 32
`ifdef BRU_PERF_CNT_EN
    , parameter int PERF_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_jump,
    input  logic            in_branch,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs_val,
    input  logic [XLEN-1:0] in_rt_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_cond,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_link,
    output logic            out_illegal
`ifdef BRU_PERF_CNT_EN
    , output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_total
`endif
);

    typedef enum logic [3:0] {
        C_NOP    = 4'd0,
        C_E      = 4'd1,
        C_NE     = 4'd2,
        C_L      = 4'd3,
        C_G      = 4'd4,
        C_LE     = 4'd5,
        C_GE     = 4'd6,
        C_ALWAYS = 4'd7,
        C_REG    = 4'd8
    } cond_e;

    logic            s1_valid_q, s1_valid_d;
    cond_e           s1_cond_q, s1_cond_d;
    logic            s1_link_q, s1_link_d;
    logic            s1_illegal_q, s1_illegal_d;
    logic [XLEN-1:0] s1_pc_q, s1_pc_d;
    logic [XLEN-1:0] s1_rs_q, s1_rs_d;
    logic [XLEN-1:0] s1_rt_q, s1_rt_d;
    logic [XLEN-1:0] s1_imm_q, s1_imm_d;
    logic [25:0]     s1_idx_q, s1_idx_d;

    logic            s2_valid_q, s2_valid_d;
    logic [3:0]      s2_cond_q, s2_cond_d;
    logic            s2_taken_q, s2_taken_d;
    logic [XLEN-1:0] s2_target_q, s2_target_d;
    logic            s2_link_q, s2_link_d;
    logic            s2_illegal_q, s2_illegal_d;

    logic s2_adv;
    logic s1_adv;
    logic s1_load;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = s1_adv && in_valid && !flush;

    logic [5:0] opc;
    logic [4:0] rt_f;
    logic [5:0] funct;
    cond_e      dec_cond;
    logic       dec_link;
    logic       dec_illegal;

    assign opc   = in_inst[31:26];
    assign rt_f  = in_inst[20:16];
    assign funct = in_inst[5:0];

    always_comb begin
        dec_cond    = C_NOP;
        dec_link    = 1'b0;
        dec_illegal = 1'b0;
        unique case ({in_jump, in_branch})
            2'b01: begin
                unique case (opc)
                    6'b000001: begin
                        if (rt_f == 5'd0)
                            dec_cond = C_L;
                        else if (rt_f == 5'd1)
                            dec_cond = C_GE;
                    end
                    6'b000100: dec_cond = C_E;
                    6'b000101: dec_cond = C_NE;
                    6'b000110: if (rt_f == 5'd0) dec_cond = C_LE;
                    6'b000111: if (rt_f == 5'd0) dec_cond = C_G;
                    default:   dec_cond = C_NOP;
                endcase
            end
            2'b10: begin
                unique case (opc)
                    6'b000010: dec_cond = C_ALWAYS;
                    6'b000011: begin
                        dec_cond = C_ALWAYS;
                        dec_link = 1'b1;
                    end
                    6'b000000: if (funct == 6'b001000) dec_cond = C_REG;
                    default:   dec_cond = C_NOP;
                endcase
            end
            2'b11:   dec_illegal = 1'b1;
            default: dec_cond = C_NOP;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_cond_d    = s1_cond_q;
        s1_link_d    = s1_link_q;
        s1_illegal_d = s1_illegal_q;
        s1_pc_d      = s1_pc_q;
        s1_rs_d      = s1_rs_q;
        s1_rt_d      = s1_rt_q;
        s1_imm_d     = s1_imm_q;
        s1_idx_d     = s1_idx_q;
        if (flush)
            s1_valid_d = 1'b0;
        else if (s1_adv)
            s1_valid_d = in_valid;
        if (s1_load) begin
            s1_cond_d    = dec_cond;
            s1_link_d    = dec_link;
            s1_illegal_d = dec_illegal;
            s1_pc_d      = in_pc;
            s1_rs_d      = in_rs_val;
            s1_rt_d      = in_rt_val;
            s1_imm_d     = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
            s1_idx_d     = in_inst[25:0];
        end
    end

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;
    logic            s1_neg;
    logic            s1_zero;
    logic            ev_taken;
    logic [XLEN-1:0] ev_target;

    assign pc4     = s1_pc_q + XLEN'(4);
    assign br_tgt  = pc4 + {s1_imm_q[XLEN-3:0], 2'b00};
    assign j_tgt   = {pc4[XLEN-1:28], s1_idx_q, 2'b00};
    assign s1_neg  = s1_rs_q[XLEN-1];
    assign s1_zero = (s1_rs_q == '0);

    always_comb begin
        ev_taken  = 1'b0;
        ev_target = pc4;
        unique case (s1_cond_q)
            C_E:      ev_taken = (s1_rs_q == s1_rt_q);
            C_NE:     ev_taken = (s1_rs_q != s1_rt_q);
            C_L:      ev_taken = s1_neg;
            C_G:      ev_taken = !s1_neg && !s1_zero;
            C_LE:     ev_taken = s1_neg || s1_zero;
            C_GE:     ev_taken = !s1_neg;
            C_ALWAYS: ev_taken = 1'b1;
            C_REG:    ev_taken = 1'b1;
            default:  ev_taken = 1'b0;
        endcase
        if (ev_taken) begin
            if (s1_cond_q == C_ALWAYS)
                ev_target = j_tgt;
            else if (s1_cond_q == C_REG)
                ev_target = s1_rs_q;
            else
                ev_target = br_tgt;
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_cond_d    = s2_cond_q;
        s2_taken_d   = s2_taken_q;
        s2_target_d  = s2_target_q;
        s2_link_d    = s2_link_q;
        s2_illegal_d = s2_illegal_q;
        if (flush)
            s2_valid_d = 1'b0;
        else if (s2_adv)
            s2_valid_d = s1_valid_q;
        // Data only moves with a live entry so idle outputs keep their last value.
        if (s2_adv && s1_valid_q && !flush) begin
            s2_cond_d    = s1_cond_q;
            s2_taken_d   = ev_taken;
            s2_target_d  = ev_target;
            s2_link_d    = s1_link_q;
            s2_illegal_d = s1_illegal_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cond_q    <= C_NOP;
            s1_link_q    <= 1'b0;
            s1_illegal_q <= 1'b0;
            s1_pc_q      <= '0;
            s1_rs_q      <= '0;
            s1_rt_q      <= '0;
            s1_imm_q     <= '0;
            s1_idx_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_cond_q    <= 4'd0;
            s2_taken_q   <= 1'b0;
            s2_target_q  <= '0;
            s2_link_q    <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cond_q    <= s1_cond_d;
            s1_link_q    <= s1_link_d;
            s1_illegal_q <= s1_illegal_d;
            s1_pc_q      <= s1_pc_d;
            s1_rs_q      <= s1_rs_d;
            s1_rt_q      <= s1_rt_d;
            s1_imm_q     <= s1_imm_d;
            s1_idx_q     <= s1_idx_d;
            s2_valid_q   <= s2_valid_d;
            s2_cond_q    <= s2_cond_d;
            s2_taken_q   <= s2_taken_d;
            s2_target_q  <= s2_target_d;
            s2_link_q    <= s2_link_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_cond    = s2_cond_q;
    assign out_taken   = s2_taken_q;
    assign out_target  = s2_target_q;
    assign out_link    = s2_link_q;
    assign out_illegal = s2_illegal_q;

`ifdef BRU_PERF_CNT_EN
    logic [PERF_W-1:0] perf_taken_q, perf_taken_d;
    logic [PERF_W-1:0] perf_total_q, perf_total_d;
    logic              is_branch_cond;

    assign is_branch_cond = (s2_cond_q >= 4'd1) && (s2_cond_q <= 4'd6);

    always_comb begin
        perf_taken_d = perf_taken_q;
        perf_total_d = perf_total_q;
        if (s2_valid_q && out_ready && is_branch_cond) begin
            perf_total_d = perf_total_q + 1'b1;
            if (s2_taken_q)
                perf_taken_d = perf_taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_taken_q <= '0;
            perf_total_q <= '0;
        end else begin
            perf_taken_q <= perf_taken_d;
            perf_total_q <= perf_total_d;
        end
    end

    assign perf_taken = perf_taken_q;
    assign perf_total = perf_total_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: decode, evaluate, handshake, flush and reset.
// Perf counter checks run only when BRU_PERF_CNT_EN is defined.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_jump;
    logic        in_branch;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_cond;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_link;
    logic        out_illegal;
`ifdef BRU_PERF_CNT_EN
    logic [15:0] perf_taken;
    logic [15:0] perf_total;
`endif

    int checks;
    int errors;

    branch_resolve_unit dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_jump     (in_jump),
        .in_branch   (in_branch),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cond    (out_cond),
        .out_taken   (out_taken),
        .out_target  (out_target),
        .out_link    (out_link),
        .out_illegal (out_illegal)
`ifdef BRU_PERF_CNT_EN
        , .perf_taken (perf_taken),
        .perf_total  (perf_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one entry starting at posedge+1, returns at posedge+1 after it is taken.
    task automatic send_one(input logic j, input logic b, input logic [31:0] inst,
                            input logic [31:0] pc, input logic [31:0] rs,
                            input logic [31:0] rt);
        bit ok;
        in_valid  = 1'b1;
        in_jump   = j;
        in_branch = b;
        in_inst   = inst;
        in_pc     = pc;
        in_rs_val = rs;
        in_rt_val = rt;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready=0 for 20 cycles, required 1");
        end
        in_valid  = 1'b0;
        in_jump   = 1'b0;
        in_branch = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_cond !== 4'd0 || out_target !== 32'd0 ||
            out_taken !== 1'b0 || out_link !== 1'b0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: v=%b c=%0d t=%h tk=%b l=%b i=%b, required all 0",
                     out_valid, out_cond, out_target, out_taken, out_link, out_illegal);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_beq;
        out_ready = 1'b1;
        send_one(1'b0, 1'b1, 32'h1085_0003, 32'h100, 32'd5, 32'd5);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_cond !== 4'd1 || out_taken !== 1'b1 ||
            out_target !== 32'h110) begin
            errors++;
            $display("FAIL beq: v=%b c=%0d tk=%b t=%h, required 1 1 1 00000110",
                     out_valid, out_cond, out_taken, out_target);
        end
        @(posedge clk);
        #1;
        send_one(1'b0, 1'b1, 32'h1485_FFFF, 32'h100, 32'd1, 32'd2);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_cond !== 4'd2 || out_taken !== 1'b1 ||
            out_target !== 32'h100) begin
            errors++;
            $display("FAIL bne_neg_imm: v=%b c=%0d tk=%b t=%h, required 1 2 1 00000100",
                     out_valid, out_cond, out_taken, out_target);
        end
        @(posedge clk);
        #1;
        send_one(1'b0, 1'b1, 32'h1085_0000, 32'hFFFF_FFFC, 32'd7, 32'd7);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_taken !== 1'b1 || out_target !== 32'h0) begin
            errors++;
            $display("FAIL beq_wrap: tk=%b t=%h, required 1 00000000",
                     out_taken, out_target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bgtz;
        out_ready = 1'b1;
        send_one(1'b0, 1'b1, 32'h1C20_0004, 32'h100, 32'hFFFF_FFFF, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_cond !== 4'd4 || out_taken !== 1'b0 || out_target !== 32'h104) begin
            errors++;
            $display("FAIL bgtz_neg: c=%0d tk=%b t=%h, required 4 0 00000104",
                     out_cond, out_taken, out_target);
        end
        @(posedge clk);
        #1;
        send_one(1'b0, 1'b1, 32'h1C20_0004, 32'h100, 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_cond !== 4'd4 || out_taken !== 1'b1 || out_target !== 32'h114) begin
            errors++;
            $display("FAIL bgtz_pos: c=%0d tk=%b t=%h, required 4 1 00000114",
                     out_cond, out_taken, out_target);
        end
        @(posedge clk);
        #1;
        send_one(1'b0, 1'b1, 32'h0401_0002, 32'h200, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_cond !== 4'd6 || out_taken !== 1'b1 || out_target !== 32'h20C) begin
            errors++;
            $display("FAIL bgez_zero: c=%0d tk=%b t=%h, required 6 1 0000020c",
                     out_cond, out_taken, out_target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_jal_jr;
        out_ready = 1'b1;
        send_one(1'b1, 1'b0, 32'h0C00_0010, 32'h4000_0000, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_cond !== 4'd7 || out_taken !== 1'b1 || out_link !== 1'b1 ||
            out_target !== 32'h4000_0040) begin
            errors++;
            $display("FAIL jal: c=%0d tk=%b l=%b t=%h, required 7 1 1 40000040",
                     out_cond, out_taken, out_link, out_target);
        end
        @(posedge clk);
        #1;
        send_one(1'b1, 1'b0, 32'h03E0_0008, 32'h300, 32'h1234, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_cond !== 4'd8 || out_taken !== 1'b1 || out_link !== 1'b0 ||
            out_target !== 32'h1234) begin
            errors++;
            $display("FAIL jr: c=%0d tk=%b l=%b t=%h, required 8 1 0 00001234",
                     out_cond, out_taken, out_link, out_target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int          sent;
        int          rcv;
        logic        stalled;
        logic [31:0] held;
        logic [31:0] pcs [4];
        pcs     = '{32'h200, 32'h300, 32'h400, 32'h500};
        sent    = 0;
        rcv     = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 20 && rcv < 4; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            in_branch = 1'b1;
            in_jump   = 1'b0;
            in_inst   = 32'h1085_0003;
            in_pc     = (sent < 4) ? pcs[sent] : 32'h0;
            in_rs_val = 32'd9;
            in_rt_val = 32'd9;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    errors++;
                    $display("FAIL b2b_in_ready: in_ready=%b sent=%0d, required 0 2",
                             in_ready, sent);
                end
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_target !== held) begin
                    errors++;
                    $display("FAIL b2b_hold: v=%b t=%h, required 1 %h",
                             out_valid, out_target, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (rcv >= 4 || out_target !== pcs[rcv] + 32'd16) begin
                    errors++;
                    $display("FAIL b2b_order: idx=%0d t=%h", rcv, out_target);
                end
                rcv++;
            end
            stalled = out_valid && !out_ready;
            held    = out_target;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_branch = 1'b0;
        checks++;
        if (rcv != 4 || sent != 4) begin
            errors++;
            $display("FAIL b2b_count: rcv=%0d sent=%0d, required 4 4", rcv, sent);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_dup: out_valid=%b, required 0", out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        send_one(1'b1, 1'b1, 32'h1085_0003, 32'h100, 32'd5, 32'd5);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_taken !== 1'b0 ||
            out_cond !== 4'd0 || out_target !== 32'h104) begin
            errors++;
            $display("FAIL illegal: v=%b i=%b tk=%b c=%0d t=%h, required 1 1 0 0 00000104",
                     out_valid, out_illegal, out_taken, out_cond, out_target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        send_one(1'b0, 1'b1, 32'h1085_0003, 32'h600, 32'd1, 32'd1);
        send_one(1'b0, 1'b1, 32'h1085_0003, 32'h700, 32'd1, 32'd1);
        in_valid  = 1'b1;
        in_branch = 1'b1;
        in_inst   = 32'h1085_0003;
        in_pc     = 32'h800;
        flush     = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: out_valid=%b, required 1", out_valid);
        end
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_branch = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop: cycle %0d out_valid=%b t=%h, required 0",
                         c, out_valid, out_target);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rst_mid;
        out_ready = 1'b0;
        send_one(1'b1, 1'b0, 32'h0C00_0010, 32'h4000_0000, 32'd0, 32'd0);
        send_one(1'b0, 1'b1, 32'h1085_0003, 32'h100, 32'd5, 32'd5);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_cond !== 4'd0 || out_target !== 32'd0 ||
            out_taken !== 1'b0 || out_link !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: v=%b c=%0d t=%h tk=%b l=%b r=%b, required 0 0 0 0 0 1",
                     out_valid, out_cond, out_target, out_taken, out_link, in_ready);
        end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: out_valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef BRU_PERF_CNT_EN
    task automatic test_perf;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            send_one(1'b0, 1'b1, 32'h1085_0003, 32'h100, 32'd5, 32'd5);
        for (int k = 0; k < 2; k++)
            send_one(1'b0, 1'b1, 32'h1485_0003, 32'h100, 32'd5, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (perf_total !== 16'd5 || perf_taken !== 16'd3) begin
            errors++;
            $display("FAIL perf: total=%0d taken=%0d, required 5 3",
                     perf_total, perf_taken);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_jump   = 1'b0;
        in_branch = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_beq();
        test_bgtz();
        test_jal_jr();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_rst_mid();
`ifdef BRU_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
